// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a 3-input circuit through all codes, captures its truth table
// and compares it with an expected table, reporting the verdict on an RGB LED.
module truth_table_scanner #(
   parameter int SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   output logic [2:0] abc_o,
   input  logic       y_i,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       pass,
   output logic       fail,
   output logic [2:0] led_rgb
);
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   state_t     state;
   logic [2:0] idx;
   logic [7:0] cnt;
   logic [7:0] exp_q;
   logic [7:0] final_res;
   // only used on the last sample, so the incoming bit lands in position 7
   always_comb final_res = {y_i, result[6:0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         exp_q   <= '0;
         abc_o   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         pass    <= 1'b0;
         fail    <= 1'b0;
         led_rgb <= 3'b000;
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= DRIVE;
               idx     <= '0;
               abc_o   <= '0;
               cnt     <= '0;
               result  <= '0;
               pass    <= 1'b0;
               fail    <= 1'b0;
               exp_q   <= expected;
               busy    <= 1'b1;
               led_rgb <= 3'b001;
            end
            DRIVE: begin
               cnt <= cnt + 8'd1;
               if (cnt == 8'(SETTLE_CYC - 1)) state <= SAMPLE;
            end
            SAMPLE: begin
               result[idx] <= y_i;
               if (idx == 3'd7) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  pass    <= final_res == exp_q;
                  fail    <= final_res != exp_q;
                  led_rgb <= final_res == exp_q ? 3'b010 : 3'b100;
               end else begin
                  state <= DRIVE;
                  idx   <= idx + 3'd1;
                  abc_o <= idx + 3'd1;
                  cnt   <= '0;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: table-driven and random scans of two scanner instances
// (settle 2 and settle 1) driving a modelled 3-input circuit.
module tb_truth_table_scanner;
   logic clk, rst, start, sel;
   logic [7:0] expected, tbl;
   logic [2:0] abc0, abc1, led0, led1, abc, led;
   logic [7:0] res0, res1, res;
   logic busy0, busy1, done0, done1, pass0, pass1, fail0, fail1;
   logic busy, done, pass_o, fail_o;
   int tests = 0, fails = 0;

   truth_table_scanner #(.SETTLE_CYC(2)) dut0 (.clk(clk), .rst(rst), .start(start & ~sel),
      .expected(expected), .abc_o(abc0), .y_i(tbl[abc0]), .busy(busy0), .done(done0),
      .result(res0), .pass(pass0), .fail(fail0), .led_rgb(led0));
   truth_table_scanner #(.SETTLE_CYC(1)) dut1 (.clk(clk), .rst(rst), .start(start & sel),
      .expected(expected), .abc_o(abc1), .y_i(tbl[abc1]), .busy(busy1), .done(done1),
      .result(res1), .pass(pass1), .fail(fail1), .led_rgb(led1));

   assign abc    = sel ? abc1 : abc0;
   assign led    = sel ? led1 : led0;
   assign res    = sel ? res1 : res0;
   assign busy   = sel ? busy1 : busy0;
   assign done   = sel ? done1 : done0;
   assign pass_o = sel ? pass1 : pass0;
   assign fail_o = sel ? fail1 : fail0;

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {int fn; int s; logic [7:0] ev; logic [7:0] er;} vec_t;
   vec_t vecs[4];

   function automatic bit model_y(int fn, int code);
      bit a = code[2], b = code[1], c = code[0];
      return fn == 0 ? ((a & b) | c) : (a ^ b ^ c);
   endfunction

   function automatic logic [7:0] table_of(int fn);
      logic [7:0] t;
      for (int i = 0; i < 8; i++) t[i] = model_y(fn, i);
      return t;
   endfunction

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
      end
   endtask

   task automatic scan(input int s, input logic [7:0] ev, input logic [7:0] er, input bit extra);
      int d = 8 * (s + 1) + 1;
      bit ok = (er == ev);
      sel = (s == 1);
      expected = ev;
      start = 1;
      @(negedge clk);
      start = 0;
      for (int k = 1; k <= d + 1; k++) begin
         if (k > 1) @(negedge clk);
         start = extra && (k == 5 || k == 20);
         if (k == 3) expected = ~ev;
         chk("busy", 32'(busy), 32'(k <= d));
         chk("done", 32'(done), 32'(k == d));
         chk("abc", 32'(abc), k < d ? 32'((k - 1) / (s + 1)) : 32'd7);
         if (k < d) chk("led_busy", 32'(led), 32'd1);
         if (k == d) begin
            chk("result", 32'(res), 32'(er));
            chk("pass", 32'(pass_o), 32'(ok));
            chk("fail", 32'(fail_o), 32'(!ok));
            chk("led", 32'(led), ok ? 32'd2 : 32'd4);
         end
      end
      start = 0;
      expected = ev;
   endtask

   initial begin
      bit seen;
      logic [7:0] ev, er;
      vecs[0] = '{0, 2, 8'hEA, 8'hEA};
      vecs[1] = '{0, 2, 8'hEB, 8'hEA};
      vecs[2] = '{1, 1, 8'h96, 8'h96};
      vecs[3] = '{1, 2, 8'h00, 8'h96};
      rst = 1; start = 0; sel = 0; expected = 0; tbl = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy0 | busy1), 0);
      chk("rst_done", 32'(done0 | done1), 0);
      chk("rst_abc", 32'(abc0 | abc1), 0);
      chk("rst_result", 32'(res0 | res1), 0);
      chk("rst_passfail", 32'(pass0 | pass1 | fail0 | fail1), 0);
      chk("rst_led", 32'(led0 | led1), 0);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         tbl = table_of(vecs[i].fn);
         scan(vecs[i].s, vecs[i].ev, vecs[i].er, i == 1);
      end

      // reset in the middle of a scan
      sel = 0; tbl = table_of(0); expected = 8'hEA; start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_abc", 32'(abc), 0);
      chk("mid_rst_result", 32'(res), 0);
      chk("mid_rst_led", 32'(led), 0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         seen |= done;
      end
      chk("mid_rst_no_done", 32'(seen), 0);
      scan(2, 8'hEA, 8'hEA, 0);

      // reset beats start in the same cycle
      rst = 1; start = 1;
      @(negedge clk);
      rst = 0; start = 0;
      chk("rst_start_busy", 32'(busy), 0);
      chk("rst_start_led", 32'(led), 0);
      @(negedge clk);
      chk("rst_start_idle", 32'(busy), 0);

      // start held high: back-to-back scans
      sel = 0; tbl = table_of(0); expected = 8'hEA; start = 1;
      for (int k = 1; k <= 52; k++) begin
         @(negedge clk);
         if (k == 51) start = 0;
         chk("b2b_done", 32'(done), 32'(k == 25 || k == 51));
         if (k == 26) begin
            chk("b2b_idle", 32'(busy), 0);
            chk("b2b_pass_held", 32'(pass_o), 1);
         end
         if (k == 27) begin
            chk("b2b_busy", 32'(busy), 1);
            chk("b2b_cleared", 32'({pass_o, fail_o}), 0);
         end
         if (k == 51) chk("b2b_pass2", 32'(pass_o), 1);
      end

      // random circuits and expectations on both settle lengths
      for (int r = 0; r < 6; r++) begin
         tbl = 8'($urandom);
         er = 0;
         for (int i = 0; i < 8; i++) er[i] = tbl[i];
         ev = r[0] ? er : er ^ (8'd1 << $urandom_range(7));
         scan($urandom_range(1, 2), ev, er, r == 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
